motor_bridge_driver: RTL and testbench
======================================

Name: motor_bridge_driver

Overview:
- Consumes the 8-bit motor direction select bus from the movement FSM: two bits per motor, four motors.
- Drives the four H-bridge input pairs (in1/in2) with a shared PWM speed signal.
- Enforces a dead time on every exit from an active direction, so a bridge never sees an instant reversal.
- Flags illegal select codes per motor as sticky faults.

Parameters:
PWM_BITS, 8, width of PWM counter and duty input; period = 2^PWM_BITS clocks
DEAD_CYCLES, 50, minimum clocks both bridge inputs held low when leaving an active direction (>=1)
DEAD_W, 8, width of dead-time counter; must hold DEAD_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sel  in  8  motor direction request; motor i = sel[2i+1:2i]; 01 forward, 10 reverse, 00 coast, 11 illegal
duty  in  PWM_BITS  speed duty, shared by all motors
enable  in  1  global drive enable; 0 = coast request for all motors
fault_clr  in  1  clears fault[3:0]
in1  out  4  bridge forward input per motor, registered
in2  out  4  bridge reverse input per motor, registered
busy  out  4  motor i in dead-time interval
fault  out  4  sticky: illegal code 11 sampled on motor i

Behaviour:
- Reset (async): in1=0, in2=0, busy=0, fault=0, all motors OFF, dir=none, pwm_cnt=0, duty_q=0, dead counters=0.
- Per-motor request req_i:
  - FWD for 01, REV for 10.
  - NONE for 00, for 11, or whenever enable=0.
- Per-motor FSM, states OFF / DRIVE / DEAD, evaluated every clk:
  - OFF: req FWD/REV -> DRIVE with dir=req (no dead time); req NONE -> stay.
  - DRIVE: req==dir -> stay; any other req (opposite, NONE, illegal) -> DEAD, cnt=DEAD_CYCLES-1.
  - DEAD: cnt>0 -> cnt-1, stay. When cnt==0 the next state depends on req sampled that cycle:
    - req FWD/REV -> DRIVE with dir=req; this holds even if req equals the previous dir.
    - req NONE -> OFF.
  - Request changes during DEAD never restart or shorten the interval.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps.
  - duty_q <= duty only on the cycle pwm_cnt == all-ones, so duty changes are glitch-free at period boundary.
  - pwm_on = (pwm_cnt < duty_q): duty 0 = always off; all-ones = on for 2^PWM_BITS-1 of 2^PWM_BITS clocks.
- Outputs (registered from current state):
  - in1[i] <= DRIVE & dir==FWD & pwm_on.
  - in2[i] <= DRIVE & dir==REV & pwm_on.
  - in1[i] & in2[i] is never 1.
  - busy[i] <= (state==DEAD).
- Latency:
  - sel change OFF->FWD: state updates at edge N, in1 may rise at edge N+1, gated by pwm_on.
  - DRIVE->DEAD at edge N: pins low from edge N+1 through at least edge N+DEAD_CYCLES.
  - New direction visible no earlier than edge N+DEAD_CYCLES+1, giving exactly DEAD_CYCLES low clocks when the request is held.
- Faults:
  - fault[i] sets on any cycle with sel pair i == 11 and holds until fault_clr.
  - Set wins over a simultaneous fault_clr.
  - Faults do not block driving.
- enable=0 mid-drive: identical to coast request, so DEAD then OFF.
- rst mid-DEAD: immediate OFF, pins 0; no dead time is owed after reset.
- All four motors are independent; simultaneous transitions on several motors are allowed.

Test Plan (bench params PWM_BITS=4, DEAD_CYCLES=4):
- Reset, enable=1, duty=8, sel=0x55 -> after first wrap (cnt=15), in1=4'hF for 8 of every 16 clocks, in2=0, busy=0, fault=0.
- Motors in DRIVE FWD, sel 0x55->0xAA -> in1=0 next edge, busy=4'hF for 4 clocks, in1=in2=0 for exactly 4 clocks, then in2 follows PWM; in1&in2 never both 1.
- During DEAD, toggle sel 0xAA->0x55->0xAA -> dead interval still 4 clocks, final dir REV taken from sel at expiry.
- sel=0xC1 (motor3=11, motor0=01) -> fault=4'b1000, motor3 pins 0, motor0 drives FWD; assert fault_clr with sel=0x01 -> fault=0; fault_clr with sel=0xC1 -> fault stays 4'b1000.
- duty 8->15 written mid-period -> high time unchanged until wrap, then 15 of 16 clocks; duty=0 -> in1=in2=0 continuously.
- enable drops in DRIVE -> pins 0 next edge, busy 4 clocks, state OFF; assert rst during DEAD -> all outputs 0 asynchronously, next sel=0x55 drives without dead time.

Source files
------------

// File: rtl/motor_bridge_if.sv
// Bundles the direction-select inputs and bridge drive outputs of motor_bridge_driver.
// The master drives the requests and the slave drives the bridge pins.
interface motor_bridge_if #(
   parameter int PWM_BITS = 8
);
   logic [7:0]          sel;
   logic [PWM_BITS-1:0] duty;
   logic                enable;
   logic                fault_clr;
   logic [3:0]          in1;
   logic [3:0]          in2;
   logic [3:0]          busy;
   logic [3:0]          fault;

   modport master (
      output sel, duty, enable, fault_clr,
      input  in1, in2, busy, fault
   );

   modport slave (
      input  sel, duty, enable, fault_clr,
      output in1, in2, busy, fault
   );
endinterface

// File: rtl/motor_bridge_driver.sv
// Four-motor H-bridge driver: per-motor direction FSM with enforced dead time,
// a shared PWM speed signal, and sticky faults for illegal select codes.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_OFF   | bridge idle, both inputs low, no dead time owed
//   S_DRIVE | bridge driven in dir_q, gated by pwm_on
//   S_DEAD  | both inputs held low for DEAD_CYCLES clocks after leaving DRIVE
module motor_bridge_driver #(
   parameter int PWM_BITS    = 8,
   parameter int DEAD_CYCLES = 50,
   parameter int DEAD_W      = 8
) (
   input logic          clk,
   input logic          rst,
   motor_bridge_if.slave bus
);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_DRIVE = 2'd1,
      S_DEAD  = 2'd2
   } state_t;

   localparam logic [1:0]        D_NONE    = 2'b00;
   localparam logic [1:0]        D_FWD     = 2'b01;
   localparam logic [1:0]        D_REV     = 2'b10;
   localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYCLES - 1);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty_q;
   logic                pwm_on;

   state_t              state_q [4];
   state_t              state_d [4];
   logic [1:0]          dir_q   [4];
   logic [1:0]          dir_d   [4];
   logic [DEAD_W-1:0]   cnt_q   [4];
   logic [DEAD_W-1:0]   cnt_d   [4];
   logic [1:0]          req     [4];

   logic [3:0]          in1_q;
   logic [3:0]          in2_q;
   logic [3:0]          busy_q;
   logic [3:0]          fault_q;

   // Duty is only picked up at the period boundary so a mid-period write
   // cannot produce a runt or stretched pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
         duty_q  <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (&pwm_cnt) duty_q <= bus.duty;
      end
   end

   assign pwm_on = (pwm_cnt < duty_q);

   // Illegal codes and a global disable both collapse to a coast request.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req[i] = D_NONE;
         if (bus.enable && (bus.sel[2*i +: 2] == D_FWD || bus.sel[2*i +: 2] == D_REV))
            req[i] = bus.sel[2*i +: 2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= S_OFF;
            dir_q[i]   <= D_NONE;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            dir_q[i]   <= dir_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         dir_d[i]   = dir_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_OFF: begin
               if (req[i] != D_NONE) begin
                  state_d[i] = S_DRIVE;
                  dir_d[i]   = req[i];
               end
            end
            S_DRIVE: begin
               if (req[i] != dir_q[i]) begin
                  state_d[i] = S_DEAD;
                  cnt_d[i]   = DEAD_INIT;
               end
            end
            S_DEAD: begin
               // The interval always runs to completion; only the request
               // present at expiry decides where we go.
               if (cnt_q[i] != '0) begin
                  cnt_d[i] = cnt_q[i] - DEAD_W'(1);
               end else if (req[i] != D_NONE) begin
                  state_d[i] = S_DRIVE;
                  dir_d[i]   = req[i];
               end else begin
                  state_d[i] = S_OFF;
                  dir_d[i]   = D_NONE;
               end
            end
            default: begin
               state_d[i] = S_OFF;
               dir_d[i]   = D_NONE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in1_q   <= '0;
         in2_q   <= '0;
         busy_q  <= '0;
         fault_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            in1_q[i]  <= (state_q[i] == S_DRIVE) && (dir_q[i] == D_FWD) && pwm_on;
            in2_q[i]  <= (state_q[i] == S_DRIVE) && (dir_q[i] == D_REV) && pwm_on;
            busy_q[i] <= (state_q[i] == S_DEAD);
            if (bus.sel[2*i +: 2] == 2'b11)
               fault_q[i] <= 1'b1;
            else if (bus.fault_clr)
               fault_q[i] <= 1'b0;
         end
      end
   end

   assign bus.in1   = in1_q;
   assign bus.in2   = in2_q;
   assign bus.busy  = busy_q;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_motor_bridge_driver.sv
// Self-checking bench for motor_bridge_driver: a cycle model pushes expected
// {in1,in2,busy,fault} per clock into a queue that each test pops and compares.
module tb_motor_bridge_driver;
   localparam int PB = 4;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   motor_bridge_if #(.PWM_BITS(PB)) bus ();

   motor_bridge_driver #(.PWM_BITS(PB), .DEAD_CYCLES(DC), .DEAD_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [15:0] sb_q[$];

   logic [PB-1:0] m_cnt;
   logic [PB-1:0] m_duty;
   int            m_mode [4];   // 0 off, 1 drive, 2 dead
   logic [1:0]    m_dir  [4];
   int            m_left [4];
   logic [3:0]    e_in1, e_in2, e_busy, e_fault;

   task automatic model_reset();
      m_cnt  = '0;
      m_duty = '0;
      for (int i = 0; i < 4; i++) begin
         m_mode[i] = 0;
         m_dir[i]  = 2'b00;
         m_left[i] = 0;
      end
      e_in1 = '0; e_in2 = '0; e_busy = '0; e_fault = '0;
      sb_q.delete();
   endtask

   // Advance the model by one clock using the inputs currently driven, queue
   // the expected outputs, then let the DUT take the same edge.
   task automatic tick();
      logic       on;
      logic [1:0] p;
      logic [1:0] r;
      on = (m_cnt < m_duty);
      for (int i = 0; i < 4; i++) begin
         e_in1[i]  = (m_mode[i] == 1) && (m_dir[i] == 2'b01) && on;
         e_in2[i]  = (m_mode[i] == 1) && (m_dir[i] == 2'b10) && on;
         e_busy[i] = (m_mode[i] == 2);
         p = bus.sel[2*i +: 2];
         if (p == 2'b11) e_fault[i] = 1'b1;
         else if (bus.fault_clr) e_fault[i] = 1'b0;
         r = (bus.enable && (p == 2'b01 || p == 2'b10)) ? p : 2'b00;
         if (m_mode[i] == 0) begin
            if (r != 2'b00) begin m_mode[i] = 1; m_dir[i] = r; end
         end else if (m_mode[i] == 1) begin
            if (r != m_dir[i]) begin m_mode[i] = 2; m_left[i] = DC - 1; end
         end else begin
            if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
            else if (r != 2'b00) begin m_mode[i] = 1; m_dir[i] = r; end
            else begin m_mode[i] = 0; m_dir[i] = 2'b00; end
         end
      end
      if (m_cnt == {PB{1'b1}}) m_duty = bus.duty;
      m_cnt = m_cnt + 1'b1;
      sb_q.push_back({e_in1, e_in2, e_busy, e_fault});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] got;
      rst = 1'b1;
      bus.sel = 8'h55; bus.duty = 4'd8; bus.enable = 1'b1; bus.fault_clr = 1'b0;
      #2;
      got = {bus.in1, bus.in2, bus.busy, bus.fault};
      total++;
      if (got !== 16'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0000", got); end
      #10;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_pwm();
      logic [15:0] got, exp_v;
      int highs, rev;
      for (int k = 0; k < 16; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL pwm_start k=%0d got=%h exp=%h", k, got, exp_v); end
      end
      highs = 0; rev = 0;
      for (int k = 0; k < 16; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL pwm_run k=%0d got=%h exp=%h", k, got, exp_v); end
         if (bus.in1 === 4'hF) highs++;
         if (bus.in2 !== 4'h0 || bus.busy !== 4'h0) rev++;
      end
      total++;
      if (highs != 8) begin bad++; $display("FAIL pwm_high_count got=%0d exp=8", highs); end
      total++;
      if (rev != 0) begin bad++; $display("FAIL pwm_in2_busy_quiet got=%0d exp=0", rev); end
   endtask

   task automatic test_reversal();
      logic [15:0] got, exp_v;
      int busy_n, overlap;
      bus.sel = 8'hAA;
      busy_n = 0; overlap = 0;
      for (int k = 0; k < 14; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL reversal k=%0d got=%h exp=%h", k, got, exp_v); end
         if (bus.busy === 4'hF) busy_n++;
         if ((bus.in1 & bus.in2) !== 4'h0) overlap++;
      end
      total++;
      if (busy_n != DC) begin bad++; $display("FAIL reversal_busy_len got=%0d exp=%0d", busy_n, DC); end
      total++;
      if (overlap != 0) begin bad++; $display("FAIL reversal_overlap got=%0d exp=0", overlap); end
   endtask

   task automatic test_dead_toggle();
      logic [15:0] got, exp_v;
      logic [7:0]  seq [4];
      int busy_n, fwd_n, rev_n;
      seq[0] = 8'h55; seq[1] = 8'hAA; seq[2] = 8'h55; seq[3] = 8'hAA;
      busy_n = 0; fwd_n = 0; rev_n = 0;
      for (int k = 0; k < 24; k++) begin
         if (k < 4) bus.sel = seq[k];
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL dead_toggle k=%0d got=%h exp=%h", k, got, exp_v); end
         if (bus.busy === 4'hF) busy_n++;
         if (bus.in1 !== 4'h0) fwd_n++;
         if (bus.in2 === 4'hF) rev_n++;
      end
      total++;
      if (busy_n != DC) begin bad++; $display("FAIL toggle_busy_len got=%0d exp=%0d", busy_n, DC); end
      total++;
      if (fwd_n != 0) begin bad++; $display("FAIL toggle_fwd_seen got=%0d exp=0", fwd_n); end
      total++;
      if (rev_n == 0) begin bad++; $display("FAIL toggle_rev_resumed got=%0d exp=nonzero", rev_n); end
   endtask

   task automatic test_fault();
      logic [15:0] got, exp_v;
      bus.sel = 8'hC1;
      for (int k = 0; k < 10; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL fault_drive k=%0d got=%h exp=%h", k, got, exp_v); end
      end
      total++;
      if (bus.fault !== 4'b1000) begin bad++; $display("FAIL fault_set got=%b exp=1000", bus.fault); end
      bus.sel = 8'h01; bus.fault_clr = 1'b1;
      tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL fault_clr_cycle got=%h exp=%h", got, exp_v); end
      total++;
      if (bus.fault !== 4'b0000) begin bad++; $display("FAIL fault_cleared got=%b exp=0000", bus.fault); end
      bus.sel = 8'hC1;
      tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL fault_set_wins_cycle got=%h exp=%h", got, exp_v); end
      total++;
      if (bus.fault !== 4'b1000) begin bad++; $display("FAIL fault_set_wins got=%b exp=1000", bus.fault); end
      bus.fault_clr = 1'b0;
      bus.sel = 8'h01;
      tick(); exp_v = sb_q.pop_front();
      bus.fault_clr = 1'b1;
      tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL fault_final_clear got=%h exp=%h", got, exp_v); end
      bus.fault_clr = 1'b0;
   endtask

   task automatic test_duty();
      logic [15:0] got, exp_v;
      int guard, highs, active;
      bus.sel = 8'h55; bus.duty = 4'd8;
      guard = 0;
      while (m_cnt != 4'd5 || guard < 20) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL duty_settle g=%0d got=%h exp=%h", guard, got, exp_v); end
         guard++;
         if (guard > 60) break;
      end
      bus.duty = 4'd15;
      guard = 0;
      while (m_cnt != 4'd0 && guard < 20) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL duty_old_period g=%0d got=%h exp=%h", guard, got, exp_v); end
         guard++;
      end
      total++;
      if (m_cnt != 4'd0) begin bad++; $display("FAIL duty_wrap_timeout got=%0d exp=0", m_cnt); end
      highs = 0;
      for (int k = 0; k < 16; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL duty15 k=%0d got=%h exp=%h", k, got, exp_v); end
         if (bus.in1 === 4'hF) highs++;
      end
      total++;
      if (highs != 15) begin bad++; $display("FAIL duty15_high_count got=%0d exp=15", highs); end
      bus.duty = 4'd0;
      for (int k = 0; k < 16; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL duty0_load k=%0d got=%h exp=%h", k, got, exp_v); end
      end
      active = 0;
      for (int k = 0; k < 16; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL duty0 k=%0d got=%h exp=%h", k, got, exp_v); end
         if ((bus.in1 | bus.in2) !== 4'h0) active++;
      end
      total++;
      if (active != 0) begin bad++; $display("FAIL duty0_pins_active got=%0d exp=0", active); end
   endtask

   task automatic test_enable_drop();
      logic [15:0] got, exp_v;
      int busy_n;
      bus.duty = 4'd8;
      for (int k = 0; k < 20; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL enable_pre k=%0d got=%h exp=%h", k, got, exp_v); end
      end
      bus.enable = 1'b0;
      busy_n = 0;
      for (int k = 0; k < 12; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL enable_drop k=%0d got=%h exp=%h", k, got, exp_v); end
         if (bus.busy === 4'hF) busy_n++;
      end
      total++;
      if (busy_n != DC) begin bad++; $display("FAIL enable_busy_len got=%0d exp=%0d", busy_n, DC); end
      got = {bus.in1, bus.in2, bus.busy, bus.fault};
      total++;
      if (got !== 16'h0) begin bad++; $display("FAIL enable_off_idle got=%h exp=0000", got); end
      bus.enable = 1'b1;
   endtask

   task automatic test_rst_in_dead();
      logic [15:0] got, exp_v;
      int busy_n, highs;
      bus.sel = 8'h55;
      for (int k = 0; k < 20; k++) begin
         tick(); exp_v = sb_q.pop_front();
      end
      bus.sel = 8'hAA;
      for (int k = 0; k < 3; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL rst_pre k=%0d got=%h exp=%h", k, got, exp_v); end
      end
      total++;
      if (bus.busy !== 4'hF) begin bad++; $display("FAIL rst_pre_busy got=%h exp=f", bus.busy); end
      rst = 1'b1;
      #1;
      got = {bus.in1, bus.in2, bus.busy, bus.fault};
      total++;
      if (got !== 16'h0) begin bad++; $display("FAIL rst_async_clear got=%h exp=0000", got); end
      model_reset();
      #1;
      rst = 1'b0;
      bus.sel = 8'h55;
      busy_n = 0; highs = 0;
      for (int k = 0; k < 24; k++) begin
         tick(); exp_v = sb_q.pop_front(); got = {bus.in1, bus.in2, bus.busy, bus.fault};
         total++;
         if (got !== exp_v) begin bad++; $display("FAIL rst_post k=%0d got=%h exp=%h", k, got, exp_v); end
         if (bus.busy !== 4'h0) busy_n++;
         if (bus.in1 === 4'hF) highs++;
      end
      total++;
      if (busy_n != 0) begin bad++; $display("FAIL rst_no_dead got=%0d exp=0", busy_n); end
      total++;
      if (highs == 0) begin bad++; $display("FAIL rst_drive_resumed got=%0d exp=nonzero", highs); end
   endtask

   initial begin
      test_reset();
      test_pwm();
      test_reversal();
      test_dead_toggle();
      test_fault();
      test_duty();
      test_enable_drop();
      test_rst_in_dead();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
